// File: rtl/gem_frame_builder_pkg.sv
// Shared K-codes, CRC-8 helper and FSM state type for the GEM trigger frame builder.
package gem_frame_builder_pkg;

   // Separator K-codes
   localparam logic [7:0]  K_BC0      = 8'h1C;
   localparam logic [7:0]  K_RESYNC   = 8'h3C;
   localparam logic [7:0]  K_OVERFLOW = 8'hFC;
   localparam logic [7:0]  K_SEQ0     = 8'hBC;
   localparam logic [7:0]  K_SEQ1     = 8'hF7;
   localparam logic [7:0]  K_SEQ2     = 8'hFB;
   localparam logic [7:0]  K_SEQ3     = 8'hFD;

   // Idle word sent on disabled links and outside RUN
   localparam logic [15:0] IDLE_WORD  = 16'hFFDC;
   localparam logic [1:0]  IDLE_ISK   = 2'b01;

   localparam logic [7:0]  CRC8_POLY  = 8'h07;

   // Word counter width, enough for FRAME_WORDS up to 8
   localparam int unsigned WCW = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // One byte of CRC-8 (MSB first, no reflection)
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   // Separator for the 2-bit sequence number
   function automatic logic [7:0] seq_kcode(input logic [1:0] seq);
      logic [7:0] k;
      case (seq)
         2'd0:    k = K_SEQ0;
         2'd1:    k = K_SEQ1;
         2'd2:    k = K_SEQ2;
         default: k = K_SEQ3;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/gem_frame_builder_link.sv
// Per-link payload capture, word multiplexing and optional CRC-8 tail byte.
module gem_frame_link
   import gem_frame_builder_pkg::*;
#(
   parameter int unsigned FRAME_WORDS = 4,
   parameter int unsigned CRC_EN      = 0
) (
   input  logic                                   clock_160,
   input  logic                                   reset_n_i,
   input  logic                                   run_i,
   input  logic                                   frame_start_i,
   input  logic                                   discard_i,
   input  logic [WCW-1:0]                         word_cnt_i,
   input  logic                                   link_en_i,
   input  logic [16*FRAME_WORDS-8-8*CRC_EN-1:0]   pl_live_i,
   input  logic [7:0]                             sep_i,
   output logic [15:0]                            tx_data_o,
   output logic [1:0]                             tx_isk_o
);

   localparam int unsigned PW = 16*FRAME_WORDS - 8 - 8*CRC_EN;
   localparam int unsigned FW_BITS = 16*FRAME_WORDS - 8;

   logic [PW-1:0]      pl_q;
   logic [PW-1:0]      pl_cur;
   logic               en_q;
   logic               en_cur;
   logic [7:0]         crc;
   logic [FW_BITS-1:0] pad;
   logic [15:0]        word;
   logic [1:0]         isk;

   // Word 0 goes out on the capture edge, so it uses the live payload and enable
   always_comb begin
      pl_cur = frame_start_i ? pl_live_i : pl_q;
      en_cur = frame_start_i ? link_en_i : en_q;
   end

   // CRC-8 over the captured payload bytes, byte 0 first
   always_comb begin
      crc = '0;
      for (int unsigned i = 0; i < PW/8; i++) begin
         crc = crc8_byte(crc, pl_q[8*i +: 8]);
      end
   end

   // Frame byte image: payload bytes, with the CRC in the final byte slot when enabled
   always_comb begin
      pad = '0;
      pad[PW-1:0] = pl_cur;
      if (CRC_EN != 0) begin
         pad[16*FRAME_WORDS-16 +: 8] = crc;
      end
   end

   // Select the word for the current position in the frame
   always_comb begin
      word = {pad[7:0], sep_i};
      isk  = 2'b01;
      for (int unsigned k = 1; k < FRAME_WORDS; k++) begin
         if (word_cnt_i == WCW'(k)) begin
            word = pad[16*k-8 +: 16];
            isk  = 2'b00;
         end
      end
   end

   // Capture registers and registered link output
   always_ff @(posedge clock_160) begin
      if (!reset_n_i) begin
         pl_q      <= '0;
         en_q      <= 1'b0;
         tx_data_o <= IDLE_WORD;
         tx_isk_o  <= IDLE_ISK;
      end else begin
         if (discard_i) begin
            pl_q <= '0;
         end else if (frame_start_i) begin
            pl_q <= pl_live_i;
            en_q <= link_en_i;
         end
         if (run_i && en_cur) begin
            tx_data_o <= word;
            tx_isk_o  <= isk;
         end else begin
            tx_data_o <= IDLE_WORD;
            tx_isk_o  <= IDLE_ISK;
         end
      end
   end

endmodule

// File: rtl/gem_frame_builder.sv
// GEM trigger-link frame builder: FSM, frame timing, separator and miss counting.
module gem_frame_builder
   import gem_frame_builder_pkg::*;
#(
   parameter int unsigned NUM_LINKS      = 4,
   parameter int unsigned FRAME_WORDS    = 4,
   parameter int unsigned CRC_EN         = 0,
   parameter int unsigned FRAME_CTRL_TTC = 1
) (
   input  logic                                              clock_160,
   input  logic                                              reset_n_i,
   input  logic                                              tx_ready_i,
   input  logic [NUM_LINKS-1:0]                              link_en_i,
   input  logic                                              pl_valid_i,
   output logic                                              pl_ready_o,
   input  logic [NUM_LINKS*(16*FRAME_WORDS-8-8*CRC_EN)-1:0]  pl_data_i,
   input  logic                                              pl_bc0_i,
   input  logic                                              pl_resync_i,
   input  logic                                              pl_overflow_i,
   input  logic [1:0]                                        pl_bxn_i,
   output logic [NUM_LINKS*16-1:0]                           tx_data_o,
   output logic [NUM_LINKS*2-1:0]                            tx_isk_o,
   output logic [15:0]                                       missed_cnt_o,
   input  logic                                              missed_clr_i
);

   localparam int unsigned PW = 16*FRAME_WORDS - 8 - 8*CRC_EN;

   state_t         state;
   state_t         state_nxt;
   logic [WCW-1:0] word_cnt;
   logic           frame_start;
   logic           run_ok;
   logic [1:0]     seq_q;
   logic [1:0]     lcnt;
   logic [1:0]     seq;
   logic [7:0]     sep;

   // State register
   always_ff @(posedge clock_160) begin
      if (!reset_n_i) state <= IDLE;
      else            state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tx_ready_i)  state_nxt = RUN;
         RUN:     if (!tx_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      frame_start = (state == RUN) && (word_cnt == '0);
      run_ok      = (state == RUN) && tx_ready_i;
      pl_ready_o  = frame_start;
   end

   // Word position within the frame; forced to 0 whenever a frame cannot continue
   always_ff @(posedge clock_160) begin
      if (!reset_n_i || !run_ok)                  word_cnt <= '0;
      else if (word_cnt == WCW'(FRAME_WORDS-1))   word_cnt <= '0;
      else                                        word_cnt <= word_cnt + WCW'(1);
   end

   // Sequence number and separator for the frame starting this cycle
   always_comb begin
      if (FRAME_CTRL_TTC != 0) seq = pl_valid_i ? pl_bxn_i : 2'(seq_q + 2'd1);
      else                     seq = lcnt;
      if (pl_valid_i && pl_bc0_i)           sep = K_BC0;
      else if (pl_valid_i && pl_resync_i)   sep = K_RESYNC;
      else if (pl_valid_i && pl_overflow_i) sep = K_OVERFLOW;
      else                                  sep = seq_kcode(seq);
   end

   // Last used sequence number and local frame counter (restarts on every RUN entry)
   always_ff @(posedge clock_160) begin
      if (!reset_n_i) begin
         seq_q <= '0;
         lcnt  <= '0;
      end else begin
         if (state == IDLE)    lcnt <= '0;
         else if (frame_start) lcnt <= lcnt + 2'd1;
         if (frame_start)      seq_q <= seq;
      end
   end

   // Saturating count of frames sent without a payload; a coincident clear counts the new miss
   always_ff @(posedge clock_160) begin
      if (!reset_n_i) begin
         missed_cnt_o <= '0;
      end else if (frame_start && !pl_valid_i) begin
         if (missed_clr_i)                   missed_cnt_o <= 16'd1;
         else if (missed_cnt_o != 16'hFFFF)  missed_cnt_o <= missed_cnt_o + 16'd1;
      end else if (missed_clr_i) begin
         missed_cnt_o <= '0;
      end
   end

   for (genvar n = 0; n < NUM_LINKS; n++) begin : g_link
      logic [PW-1:0] pl_live;
      assign pl_live = pl_valid_i ? pl_data_i[n*PW +: PW] : '0;

      gem_frame_link #(
         .FRAME_WORDS (FRAME_WORDS),
         .CRC_EN      (CRC_EN)
      ) u_link (
         .clock_160     (clock_160),
         .reset_n_i     (reset_n_i),
         .run_i         (run_ok),
         .frame_start_i (frame_start),
         .discard_i     (!tx_ready_i),
         .word_cnt_i    (word_cnt),
         .link_en_i     (link_en_i[n]),
         .pl_live_i     (pl_live),
         .sep_i         (sep),
         .tx_data_o     (tx_data_o[16*n +: 16]),
         .tx_isk_o      (tx_isk_o[2*n +: 2])
      );
   end

endmodule

// File: tb/tb_gem_frame_builder.sv
// Scoreboard bench for gem_frame_builder: a default instance (4 links, TTC sequence)
// and a 2-link CRC instance with a local frame counter share the control inputs.
module tb_gem_frame_builder;

   localparam int FW  = 4;
   localparam int PWA = 56;
   localparam int PWB = 48;

   logic              clock_160;
   logic              reset_n_i;
   logic              tx_ready_i;
   logic              pl_valid_i;
   logic              pl_bc0_i, pl_resync_i, pl_overflow_i;
   logic [1:0]        pl_bxn_i;
   logic              missed_clr_i;
   logic [3:0]        link_en_a;
   logic [1:0]        link_en_b;
   logic [4*PWA-1:0]  pl_a;
   logic [2*PWB-1:0]  pl_b;
   logic              rdy_a, rdy_b;
   logic [63:0]       txd_a;
   logic [7:0]        isk_a;
   logic [31:0]       txd_b;
   logic [3:0]        isk_b;
   logic [15:0]       miss_a, miss_b;

   gem_frame_builder #(
      .NUM_LINKS(4), .FRAME_WORDS(FW), .CRC_EN(0), .FRAME_CTRL_TTC(1)
   ) dut_a (
      .clock_160(clock_160), .reset_n_i(reset_n_i), .tx_ready_i(tx_ready_i),
      .link_en_i(link_en_a), .pl_valid_i(pl_valid_i), .pl_ready_o(rdy_a),
      .pl_data_i(pl_a), .pl_bc0_i(pl_bc0_i), .pl_resync_i(pl_resync_i),
      .pl_overflow_i(pl_overflow_i), .pl_bxn_i(pl_bxn_i), .tx_data_o(txd_a),
      .tx_isk_o(isk_a), .missed_cnt_o(miss_a), .missed_clr_i(missed_clr_i)
   );

   gem_frame_builder #(
      .NUM_LINKS(2), .FRAME_WORDS(FW), .CRC_EN(1), .FRAME_CTRL_TTC(0)
   ) dut_b (
      .clock_160(clock_160), .reset_n_i(reset_n_i), .tx_ready_i(tx_ready_i),
      .link_en_i(link_en_b), .pl_valid_i(pl_valid_i), .pl_ready_o(rdy_b),
      .pl_data_i(pl_b), .pl_bc0_i(pl_bc0_i), .pl_resync_i(pl_resync_i),
      .pl_overflow_i(pl_overflow_i), .pl_bxn_i(pl_bxn_i), .tx_data_o(txd_b),
      .tx_isk_o(isk_b), .missed_cnt_o(miss_b), .missed_clr_i(missed_clr_i)
   );

   initial begin
      clock_160 = 1'b0;
      forever #3 clock_160 = ~clock_160;
   end

   typedef struct packed {
      logic [63:0] da;
      logic [7:0]  ka;
      logic [31:0] db;
      logic [3:0]  kb;
      logic [15:0] ma;
      logic [15:0] mb;
      logic        ra;
      logic        rb;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   bit          m_run = 1'b0;
   int          m_t   = 0;
   logic [1:0]  m_seq_a  = 2'd0;
   logic [1:0]  m_lcnt_b = 2'd0;
   logic [15:0] m_miss [2];
   bit          m_en   [2][4];
   logic [15:0] m_word [2][4][FW];

   function automatic logic [7:0] kseq(input logic [1:0] s);
      case (s)
         2'd0: return 8'hBC;
         2'd1: return 8'hF7;
         2'd2: return 8'hFB;
         default: return 8'hFD;
      endcase
   endfunction

   // Bit-serial CRC-8, polynomial x^8+x^2+x+1, init 0
   function automatic logic [7:0] crc_model(input logic [7:0] b [8], input int n);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         for (int j = 7; j >= 0; j--) begin
            fb = c[7] ^ b[i][j];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
         end
      end
      return c;
   endfunction

   task automatic build_frame(input int inst);
      int         nl, nbytes;
      logic [1:0] s;
      logic [7:0] sep;
      logic [7:0] b [8];
      nl     = (inst == 0) ? 4 : 2;
      nbytes = (inst == 0) ? PWA/8 : PWB/8;
      if (inst == 0) begin
         s = pl_valid_i ? pl_bxn_i : 2'(m_seq_a + 2'd1);
         m_seq_a = s;
      end else begin
         s = m_lcnt_b;
         m_lcnt_b = 2'(m_lcnt_b + 2'd1);
      end
      if (pl_valid_i && pl_bc0_i)           sep = 8'h1C;
      else if (pl_valid_i && pl_resync_i)   sep = 8'h3C;
      else if (pl_valid_i && pl_overflow_i) sep = 8'hFC;
      else                                  sep = kseq(s);
      for (int l = 0; l < nl; l++) begin
         for (int i = 0; i < 8; i++) b[i] = 8'h00;
         if (pl_valid_i) begin
            for (int i = 0; i < nbytes; i++)
               b[i] = (inst == 0) ? pl_a[l*PWA + 8*i +: 8] : pl_b[l*PWB + 8*i +: 8];
         end
         if (inst == 1) b[2*FW-2] = crc_model(b, nbytes);
         m_word[inst][l][0] = {b[0], sep};
         for (int k = 1; k < FW; k++) m_word[inst][l][k] = {b[2*k], b[2*k-1]};
         m_en[inst][l] = (inst == 0) ? link_en_a[l] : link_en_b[l];
      end
      if (!pl_valid_i) begin
         if (missed_clr_i)                 m_miss[inst] = 16'd1;
         else if (m_miss[inst] != 16'hFFFF) m_miss[inst] = m_miss[inst] + 16'd1;
      end else if (missed_clr_i) begin
         m_miss[inst] = 16'd0;
      end
   endtask

   // Predict the outputs after the coming clock edge and queue them
   task automatic model_edge();
      exp_t e;
      int   w;
      e.da = {4{16'hFFDC}};
      e.ka = {4{2'b01}};
      e.db = {2{16'hFFDC}};
      e.kb = {2{2'b01}};
      if (!reset_n_i) begin
         m_run = 1'b0; m_t = 0; m_seq_a = 2'd0; m_lcnt_b = 2'd0;
         m_miss[0] = 16'd0; m_miss[1] = 16'd0;
         for (int i = 0; i < 2; i++) for (int l = 0; l < 4; l++) m_en[i][l] = 1'b0;
      end else if (!m_run) begin
         if (missed_clr_i) begin m_miss[0] = 16'd0; m_miss[1] = 16'd0; end
         if (tx_ready_i) begin m_run = 1'b1; m_t = 0; m_lcnt_b = 2'd0; end
      end else begin
         w = m_t;
         if (w == 0) begin
            build_frame(0);
            build_frame(1);
         end else if (missed_clr_i) begin
            m_miss[0] = 16'd0; m_miss[1] = 16'd0;
         end
         if (tx_ready_i) begin
            for (int l = 0; l < 4; l++)
               if (m_en[0][l]) begin e.da[16*l +: 16] = m_word[0][l][w]; e.ka[2*l +: 2] = (w == 0) ? 2'b01 : 2'b00; end
            for (int l = 0; l < 2; l++)
               if (m_en[1][l]) begin e.db[16*l +: 16] = m_word[1][l][w]; e.kb[2*l +: 2] = (w == 0) ? 2'b01 : 2'b00; end
            m_t = (w + 1) % FW;
         end else begin
            m_run = 1'b0; m_t = 0;
         end
      end
      e.ma = m_miss[0];
      e.mb = m_miss[1];
      e.ra = m_run && (m_t == 0);
      e.rb = e.ra;
      q.push_back(e);
   endtask

   task automatic tick();
      model_edge();
      @(negedge clock_160);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Monitor: compare every cycle's outputs against the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(posedge clock_160);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("txd_a", 64'(txd_a), 64'(e.da));
            chk("isk_a", 64'(isk_a), 64'(e.ka));
            chk("txd_b", 64'(txd_b), 64'(e.db));
            chk("isk_b", 64'(isk_b), 64'(e.kb));
            chk("miss_a", 64'(miss_a), 64'(e.ma));
            chk("miss_b", 64'(miss_b), 64'(e.mb));
            chk("rdy_a", 64'(rdy_a), 64'(e.ra));
            chk("rdy_b", 64'(rdy_b), 64'(e.rb));
         end
      end
   end

   task automatic rand_payload();
      for (int i = 0; i < 7; i++) pl_a[32*i +: 32] = $urandom();
      for (int i = 0; i < 3; i++) pl_b[32*i +: 32] = $urandom();
   endtask

   initial begin
      reset_n_i = 1'b0; tx_ready_i = 1'b0; pl_valid_i = 1'b0;
      pl_bc0_i = 1'b0; pl_resync_i = 1'b0; pl_overflow_i = 1'b0;
      pl_bxn_i = 2'd0; missed_clr_i = 1'b0;
      link_en_a = 4'hF; link_en_b = 2'b01;
      pl_a = '0; pl_b = '0;
      @(negedge clock_160);

      // Reset state, including tx_ready asserted during reset
      repeat (2) tick();
      tx_ready_i = 1'b1;
      tick();

      // Known payload frames with bxn 0..3
      reset_n_i = 1'b1;
      pl_valid_i = 1'b1;
      rand_payload();
      pl_a[55:0] = 56'h00112233445566;
      pl_b[47:0] = 48'h010203040506;
      tick();
      for (int f = 0; f < 5; f++) begin
         pl_bxn_i = 2'(f);
         repeat (FW) tick();
      end

      // bc0 with overflow, then resync with overflow, then overflow alone
      pl_bc0_i = 1'b1; pl_overflow_i = 1'b1;
      repeat (FW) tick();
      pl_bc0_i = 1'b0; pl_resync_i = 1'b1;
      repeat (FW) tick();
      pl_resync_i = 1'b0;
      repeat (FW) tick();
      pl_overflow_i = 1'b0;

      // Clear, three empty frames, clear; then clear coinciding with a miss
      missed_clr_i = 1'b1;
      tick();
      missed_clr_i = 1'b0;
      repeat (FW-1) tick();
      pl_valid_i = 1'b0;
      repeat (3*FW) tick();
      pl_valid_i = 1'b1;
      missed_clr_i = 1'b1;
      tick();
      missed_clr_i = 1'b0;
      repeat (FW-1) tick();
      pl_valid_i = 1'b0;
      tick();
      missed_clr_i = 1'b1;
      pl_valid_i = 1'b1;
      repeat (FW-1) tick();
      pl_valid_i = 1'b0;
      missed_clr_i = 1'b1;
      tick();
      missed_clr_i = 1'b0;
      pl_valid_i = 1'b1;
      repeat (FW-1) tick();

      // tx_ready drop at word 2, then recovery
      link_en_b = 2'b11;
      rand_payload();
      repeat (2) tick();
      tx_ready_i = 1'b0;
      repeat (3) tick();
      tx_ready_i = 1'b1;
      repeat (3*FW) tick();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 1) == 0) rand_payload();
         pl_valid_i    = ($urandom_range(0, 3) != 0);
         pl_bc0_i      = ($urandom_range(0, 7) == 0);
         pl_resync_i   = ($urandom_range(0, 7) == 0);
         pl_overflow_i = ($urandom_range(0, 7) == 0);
         pl_bxn_i      = 2'($urandom_range(0, 3));
         link_en_a     = 4'($urandom_range(0, 15));
         link_en_b     = 2'($urandom_range(0, 3));
         missed_clr_i  = ($urandom_range(0, 15) == 0);
         tx_ready_i    = ($urandom_range(0, 29) != 0);
         reset_n_i     = ($urandom_range(0, 199) != 0);
         tick();
      end

      // Reset in the middle of a frame on both instances
      reset_n_i = 1'b1; tx_ready_i = 1'b1; pl_valid_i = 1'b1; missed_clr_i = 1'b0;
      pl_bc0_i = 1'b0; pl_resync_i = 1'b0; pl_overflow_i = 1'b0;
      link_en_a = 4'hF; link_en_b = 2'b01;
      repeat (2*FW + 2) tick();
      reset_n_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      repeat (3*FW) tick();

      // Drain remaining predictions with a bounded wait
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock_160);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending predictions, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gem_frame_builder.md
GEM_FRAME_BUILDER -- requirements
Module: gem_frame_builder

Interface
REQ-001 Parameter NUM_LINKS, default 4: number of trigger links driven.
REQ-002 Parameter FRAME_WORDS, default 4, range 2-8: 16-bit words per BX frame.
REQ-003 Parameter CRC_EN, default 0: when 1, the last byte of every frame is a CRC-8.
REQ-004 Parameter FRAME_CTRL_TTC, default 1: separator sequence source; 1 = bxn LSBs, 0 = local frame counter.
REQ-005 Localparam PW = 16*FRAME_WORDS-8-8*CRC_EN: payload bits per link.
REQ-006 Port clock_160, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port reset_n_i, input, 1: synchronous, active-low reset.
REQ-008 Port tx_ready_i, input, 1: MGT TX reset done; must already be synchronous to clock_160.
REQ-009 Port link_en_i, input, NUM_LINKS: per-link enable.
REQ-010 Port pl_valid_i, input, 1: payload valid.
REQ-011 Port pl_ready_o, output, 1: payload accepted this cycle.
REQ-012 Port pl_data_i, input, NUM_LINKS*PW: payload; link n is bits [n*PW +: PW].
REQ-013 Port pl_bc0_i, pl_resync_i, pl_overflow_i, input, 1 each: BX flags, qualified by pl_valid_i.
REQ-014 Port pl_bxn_i, input, 2: BX counter LSBs.
REQ-015 Port tx_data_o, output, NUM_LINKS*16: link words.
REQ-016 Port tx_isk_o, output, NUM_LINKS*2: K-character flags, bit0 = low byte.
REQ-017 Port missed_cnt_o, output, 16: frames sent without a payload.
REQ-018 Port missed_clr_i, input, 1: clears missed_cnt_o.

Function
REQ-019 The FSM SHALL have two states: IDLE and RUN.
REQ-020 IDLE SHALL go to RUN when tx_ready_i=1; RUN SHALL go to IDLE in the cycle after tx_ready_i=0.
REQ-021 In IDLE, all links SHALL output 16'hFFDC with isk 2'b01, and pl_ready_o SHALL be 0.
REQ-022 word_cnt SHALL run 0..FRAME_WORDS-1 in RUN, wrap to 0, and be held at 0 in IDLE.
REQ-023 pl_ready_o SHALL equal (state==RUN && word_cnt==0); payload and flags SHALL be captured when pl_valid_i && pl_ready_o.
REQ-024 If pl_valid_i=0 when word_cnt==0, the frame SHALL be "empty": payload all zero, flags zero, and missed_cnt_o incremented.
REQ-025 missed_cnt_o SHALL saturate at 16'hFFFF.
REQ-026 If missed_clr_i and a miss occur in the same cycle, missed_cnt_o SHALL be 1.
REQ-027 Frame word k SHALL appear on tx_data_o one cycle after word_cnt==k (latency 1).
REQ-028 Word 0 SHALL be {payload[7:0], separator} with isk 2'b01.
REQ-029 Words 1..FRAME_WORDS-1 SHALL carry the following payload bytes, LSB first, with isk 2'b00.
REQ-030 When CRC_EN=1, the high byte of the last word SHALL be CRC-8 (poly 0x07, init 0x00) over payload bytes 0..PW/8-1, computed per link.
REQ-031 Separator priority SHALL be: bc0 -> 8'h1C; else resync -> 8'h3C; else overflow -> 8'hFC.
REQ-032 Otherwise the separator SHALL be selected by seq = 0/1/2/3 -> BC/F7/FB/FD.
REQ-033 seq SHALL be pl_bxn_i captured with the payload when FRAME_CTRL_TTC=1; for an empty frame it SHALL be the previous captured value +1.
REQ-034 seq SHALL be a local 2-bit frame counter, reset on entry to RUN, when FRAME_CTRL_TTC=0.
REQ-035 A link with link_en_i=0 SHALL output the idle word 16'hFFDC/2'b01; link_en_i SHALL be sampled only at word_cnt==0.
REQ-036 If tx_ready_i drops mid-frame, the remaining words of that frame SHALL be replaced by idle and the payload discarded.

Reset
REQ-037 While reset_n_i=0 at a clock edge: state=IDLE, word_cnt=0, local counter=0, missed_cnt_o=0, pl_ready_o=0, every link tx_data_o=16'hFFDC, tx_isk_o=2'b01, capture registers zero.
REQ-038 Reset SHALL take priority over all other inputs, including mid-frame.

Structure
REQ-039 A shared package SHALL hold the K-code constants (1C, 3C, FC, BC, F7, FB, FD, idle FFDC), the CRC-8 polynomial and a CRC-8 byte function.
REQ-040 One sub-module, gem_frame_link, SHALL implement per-link word muxing and CRC, instantiated NUM_LINKS times by a generate loop.

Verification
REQ-041 Defaults, tx_ready_i=1, continuous valid, pl_bxn_i 0..3, payload link0=56'h00112233445566 -> link0 words {66,BC}/01, 4455, 2233, 0011, then next separator F7.
REQ-042 pl_bc0_i=1 and pl_overflow_i=1 together -> separator 8'h1C.
REQ-043 pl_valid_i=0 at word_cnt==0 for 3 frames -> zero payloads, missed_cnt_o=3; missed_clr_i -> 0.
REQ-044 tx_ready_i dropped at word_cnt==2 -> idle from the next cycle; RUN resumes at word 0 after tx_ready_i returns.
REQ-045 CRC_EN=1, FRAME_WORDS=4, payload 48'h010203040506 -> last-word high byte equals the CRC-8 of bytes 06,05,04,03,02,01.
REQ-046 NUM_LINKS=2, link_en_i=2'b01 -> link1 outputs constant FFDC/01 while link0 frames normally; reset_n_i=0 mid-frame -> all links idle on the next edge.
